// File: rtl/mesh_input_unit.sv
// Per-port MESH router input stage: flit FIFO, XY route of the head flit, backpressure.
// Optional MESH_INPUT_DROP_CNT_EN adds an 8-bit saturating dropped-flit counter port.
module mesh_input_unit #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned X_W        = 2,
    parameter int unsigned Y_W        = 2,
    parameter int unsigned X_LOC      = 0,
    parameter int unsigned Y_LOC      = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_data_val,
    output logic                  o_stop,
    input  logic                  i_en,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [0:4]            o_req_output,
    output logic                  o_empty
`ifdef MESH_INPUT_DROP_CNT_EN
    ,
    output logic [7:0]            o_drop_cnt
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [X_W-1:0]   X_HERE   = X_W'(X_LOC);
    localparam logic [Y_W-1:0]   Y_HERE   = Y_W'(Y_LOC);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;

    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] head;
    logic [X_W-1:0]        dest_x;
    logic [Y_W-1:0]        dest_y;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    // A full FIFO still accepts a flit when the head leaves in the same cycle.
    assign push  = i_data_val && (!full || i_en);
    assign pop   = i_en && !empty;

    assign o_stop  = full;
    assign o_empty = empty;

    // Flit storage carries no reset; empty-masking on the outputs hides stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head   = mem[rd_ptr];
    assign o_data = empty ? '0 : head;
    assign dest_x = head[DATA_WIDTH-1 -: X_W];
    assign dest_y = head[DATA_WIDTH-1-X_W -: Y_W];

    // XY dimension-order routing; y grows southward. Bit order is c,n,e,s,w.
    always_comb begin
        o_req_output = '0;
        if (!empty) begin
            if (dest_x > X_HERE) begin
                o_req_output[2] = 1'b1;
            end else if (dest_x < X_HERE) begin
                o_req_output[4] = 1'b1;
            end else if (dest_y > Y_HERE) begin
                o_req_output[3] = 1'b1;
            end else if (dest_y < Y_HERE) begin
                o_req_output[1] = 1'b1;
            end else begin
                o_req_output[0] = 1'b1;
            end
        end
    end

`ifdef MESH_INPUT_DROP_CNT_EN
    logic drop;
    assign drop = i_data_val && full && !i_en;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_drop_cnt <= '0;
        end else if (drop && (o_drop_cnt != 8'hFF)) begin
            o_drop_cnt <= o_drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mesh_input_unit.sv
// Directed table-driven bench for mesh_input_unit at router (1,1) with a 4-deep FIFO.
module tb_mesh_input_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] i_data = '0;
    logic        i_data_val = 1'b0;
    logic        i_en = 1'b0;
    logic        o_stop;
    logic [31:0] o_data;
    logic [0:4]  o_req_output;
    logic        o_empty;
`ifdef MESH_INPUT_DROP_CNT_EN
    logic [7:0]  o_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    mesh_input_unit #(
        .FIFO_DEPTH(4), .DATA_WIDTH(32), .X_W(2), .Y_W(2), .X_LOC(1), .Y_LOC(1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .i_data(i_data),
        .i_data_val(i_data_val),
        .o_stop(o_stop),
        .i_en(i_en),
        .o_data(o_data),
        .o_req_output(o_req_output),
        .o_empty(o_empty)
`ifdef MESH_INPUT_DROP_CNT_EN
        ,
        .o_drop_cnt(o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        val;
        logic [31:0] data;
        logic        en;
        logic        exp_stop;
        logic        exp_empty;
        logic [4:0]  exp_req;
        logic [31:0] exp_data;
    } vec_t;

    localparam logic [4:0] RC = 5'b10000;
    localparam logic [4:0] RN = 5'b01000;
    localparam logic [4:0] RE = 5'b00100;
    localparam logic [4:0] RS = 5'b00010;
    localparam logic [4:0] RW = 5'b00001;
    localparam logic [4:0] RZ = 5'b00000;

    function automatic logic [31:0] mk(input logic [1:0] dx, input logic [1:0] dy,
                                       input logic [27:0] payload);
        return {dx, dy, payload};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic stop, input logic empty,
                             input logic [4:0] req, input logic [31:0] data);
        check({tag, " stop"},  {31'd0, o_stop},        {31'd0, stop});
        check({tag, " empty"}, {31'd0, o_empty},       {31'd0, empty});
        check({tag, " req"},   {27'd0, o_req_output},  {27'd0, req});
        check({tag, " data"},  o_data,                 data);
    endtask

    task automatic step(input logic val, input logic [31:0] data, input logic en);
        i_data_val = val;
        i_data     = data;
        i_en       = en;
        @(posedge clk);
        #1;
        i_data_val = 1'b0;
        i_en       = 1'b0;
    endtask

    vec_t vecs[$];
    logic [31:0] fa, fb, fc, fd, fe, f0, f1, f2, f3, fg, fh;

    initial begin
        fa = mk(2'd2, 2'd1, 28'h000_00A1);
        fb = mk(2'd1, 2'd1, 28'h000_00B2);
        fc = mk(2'd1, 2'd0, 28'h000_00C3);
        fd = mk(2'd1, 2'd2, 28'h000_00D4);
        fe = mk(2'd0, 2'd1, 28'h000_00E5);
        f0 = mk(2'd3, 2'd3, 28'h123_4560);
        f1 = mk(2'd1, 2'd3, 28'h123_4561);
        f2 = mk(2'd0, 2'd0, 28'h123_4562);
        f3 = mk(2'd1, 2'd0, 28'h123_4563);
        fg = mk(2'd2, 2'd2, 28'hDEA_D000);
        fh = mk(2'd1, 2'd1, 28'h0BE_EF00);

        //            val   data  en    stop  empty req  data
        vecs.push_back('{1'b1, fa,  1'b0, 1'b0, 1'b0, RE, fa});   // dx>X_LOC -> e
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b1, RZ, '0});
        vecs.push_back('{1'b1, fb,  1'b0, 1'b0, 1'b0, RC, fb});   // (1,1) -> c
        vecs.push_back('{1'b1, fc,  1'b1, 1'b0, 1'b0, RN, fc});   // (1,0) -> n
        vecs.push_back('{1'b1, fd,  1'b1, 1'b0, 1'b0, RS, fd});   // (1,2) -> s
        vecs.push_back('{1'b1, fe,  1'b1, 1'b0, 1'b0, RW, fe});   // (0,1) -> w
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b1, RZ, '0});
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b1, RZ, '0});   // pop while empty
        vecs.push_back('{1'b1, f0,  1'b0, 1'b0, 1'b0, RE, f0});
        vecs.push_back('{1'b1, f1,  1'b0, 1'b0, 1'b0, RE, f0});
        vecs.push_back('{1'b1, f2,  1'b0, 1'b0, 1'b0, RE, f0});
        vecs.push_back('{1'b1, f3,  1'b0, 1'b1, 1'b0, RE, f0});   // full
        vecs.push_back('{1'b1, fg,  1'b0, 1'b1, 1'b0, RE, f0});   // dropped
        vecs.push_back('{1'b1, fh,  1'b1, 1'b1, 1'b0, RS, f1});   // push+pop at full
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b0, RW, f2});
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b0, RN, f3});
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b0, RC, fh});
        vecs.push_back('{1'b0, '0,  1'b1, 1'b0, 1'b1, RZ, '0});

        #12;
        check_all("reset", 1'b0, 1'b1, RZ, '0);
`ifdef MESH_INPUT_DROP_CNT_EN
        check("reset drop_cnt", {24'd0, o_drop_cnt}, 32'd0);
`endif
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].val, vecs[i].data, vecs[i].en);
            check_all($sformatf("vec%0d", i), vecs[i].exp_stop, vecs[i].exp_empty,
                      vecs[i].exp_req, vecs[i].exp_data);
`ifdef MESH_INPUT_DROP_CNT_EN
            if (i == 12) check("drop_cnt after drop", {24'd0, o_drop_cnt}, 32'd1);
`endif
        end

        // Asynchronous reset with three flits buffered, no clock edge involved.
        step(1'b1, f0, 1'b0);
        step(1'b1, f1, 1'b0);
        step(1'b1, f2, 1'b0);
        check_all("pre-reset", 1'b0, 1'b0, RE, f0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all("async reset", 1'b0, 1'b1, RZ, '0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step(1'b1, fd, 1'b0);
        check_all("post-reset push", 1'b0, 1'b0, RS, fd);
        step(1'b0, '0, 1'b1);
        check_all("post-reset pop", 1'b0, 1'b1, RZ, '0);

`ifdef MESH_INPUT_DROP_CNT_EN
        check("drop_cnt cleared", {24'd0, o_drop_cnt}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, f3, 1'b0);
        for (int i = 0; i < 260; i++) step(1'b1, fg, 1'b0);
        check("drop_cnt saturate", {24'd0, o_drop_cnt}, 32'd255);
        check_all("full after drops", 1'b1, 1'b0, RN, f3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
